// File: rtl/carry_save_adder.sv
// Purpose: compresses N signed W-bit operands into a registered carry-save (sum, cout) pair, W+E bits each.
// Latency: 1 cycle from a to sum/cout; a new operand set is accepted every cycle.
// Backpressure: none; the block is free-running and has no handshake.
module carry_save_adder #(
    parameter int N = 512,
    parameter int E = 9,
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W*N-1:0]   a,
    output logic [W+E-1:0]   sum,
    output logic [W+E-1:0]   cout
);

    localparam int WO = W + E;
    // The slot array always has room for two vectors so cout has a defined source even when N=1.
    localparam int NA = (N < 2) ? 2 : N;

    // Number of 3:2 levels needed to bring n vectors down to two.
    function automatic int tree_levels(input int n);
        int k;
        int l;
        k = n;
        l = 0;
        while (k > 2) begin
            k = (k / 3) * 2 + (k % 3);
            l++;
        end
        return l;
    endfunction

    localparam int LEVELS = tree_levels(N);

    logic [WO-1:0] sum_d;
    logic [WO-1:0] cout_d;
    logic [WO-1:0] sum_q;
    logic [WO-1:0] cout_q;

    // Wallace-style reduction: each level packs groups of three into (s, c) pairs, leftovers pass straight through.
    always_comb begin : tree
        logic [WO-1:0] cur [NA];
        logic [WO-1:0] nxt [NA];
        logic [WO-1:0] x;
        logic [WO-1:0] y;
        logic [WO-1:0] z;
        logic [WO-1:0] maj;
        int            cnt;
        int            grp;
        int            rem;

        // Unused slots stay zero so nothing undriven leaks into the result.
        cur = '{default: '0};
        nxt = '{default: '0};
        x   = '0;
        y   = '0;
        z   = '0;
        maj = '0;
        cnt = N;
        grp = 0;
        rem = 0;

        for (int i = 0; i < N; i++) begin
            cur[i] = {{E{a[i*W+W-1]}}, a[i*W +: W]};
        end

        for (int lv = 0; lv < LEVELS; lv++) begin
            nxt = '{default: '0};
            grp = cnt / 3;
            rem = cnt % 3;
            for (int g = 0; g < N / 3; g++) begin
                if (g < grp) begin
                    x          = cur[3*g];
                    y          = cur[3*g+1];
                    z          = cur[3*g+2];
                    maj        = (x & y) | (x & z) | (y & z);
                    nxt[2*g]   = x ^ y ^ z;
                    // Carry is weighted by one place; the bit pushed past the MSB is dropped (modulo 2^WO).
                    nxt[2*g+1] = {maj[WO-2:0], 1'b0};
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (r < rem) begin
                    nxt[grp*2+r] = cur[grp*3+r];
                end
            end
            cnt = grp * 2 + rem;
            cur = nxt;
        end

        sum_d  = cur[0];
        cout_d = cur[1];
    end

    // Output stage; asynchronous reset clears both vectors without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= '0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_carry_save_adder.sv
// Purpose: directed and pseudo-random checks of the carry-save adder's modular invariant across configurations.
// Latency: expects the result one rising edge after operands are driven.
// Backpressure: none; operands are driven every cycle.
module tb_carry_save_adder;

    logic          clk;
    logic          rst_n;
    logic [2047:0] a_big;
    logic [12:0]   sum_b;
    logic [12:0]   cout_b;

    logic [255:0]  r;
    logic [4:0]    s1, c1, s2, c2, s3, c3;
    logic [6:0]    s9, c9;
    logic [7:0]    s25, c25;
    logic [9:0]    s64, c64;

    int n_chk;
    int n_pass;

    carry_save_adder #(.N(512), .E(9), .W(4)) dut (
        .clk(clk), .rst_n(rst_n), .a(a_big), .sum(sum_b), .cout(cout_b));

    carry_save_adder #(.N(1), .E(1), .W(4)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .a(r[3:0]), .sum(s1), .cout(c1));
    carry_save_adder #(.N(2), .E(1), .W(4)) dut_n2 (
        .clk(clk), .rst_n(rst_n), .a(r[7:0]), .sum(s2), .cout(c2));
    carry_save_adder #(.N(3), .E(1), .W(4)) dut_n3 (
        .clk(clk), .rst_n(rst_n), .a(r[11:0]), .sum(s3), .cout(c3));
    carry_save_adder #(.N(9), .E(3), .W(4)) dut_n9 (
        .clk(clk), .rst_n(rst_n), .a(r[35:0]), .sum(s9), .cout(c9));
    carry_save_adder #(.N(25), .E(4), .W(4)) dut_n25 (
        .clk(clk), .rst_n(rst_n), .a(r[99:0]), .sum(s25), .cout(c25));
    carry_save_adder #(.N(64), .E(6), .W(4)) dut_n64 (
        .clk(clk), .rst_n(rst_n), .a(r[255:0]), .sum(s64), .cout(c64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain signed accumulate of the first n 4-bit operands of v.
    function automatic int ref_sum(input logic [2047:0] v, input int n);
        int acc;
        logic [3:0] op;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            op  = v[i*4 +: 4];
            acc = acc + int'($signed(op));
        end
        return acc;
    endfunction

    function automatic int big_total();
        return (int'(sum_b) + int'(cout_b)) & 32'h1FFF;
    endfunction

    task automatic apply(input string tag, input logic [2047:0] v, input int exp);
        a_big = v;
        @(posedge clk);
        #1;
        check(tag, big_total(), exp);
    endtask

    task automatic fill(input logic [3:0] op, output logic [2047:0] v);
        for (int i = 0; i < 512; i++) v[i*4 +: 4] = op;
    endtask

    initial begin
        logic [2047:0] v;
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        a_big  = '0;
        r      = '0;

        #12;
        check("rst_sum", int'(sum_b), 0);
        check("rst_cout", int'(cout_b), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-computed totals (mod 2^13).
        apply("zeros", '0, 32'h0000);
        fill(4'hF, v);
        apply("all_m1", v, 32'h1E00);
        fill(4'h7, v);
        apply("all_7", v, 32'h0E00);
        fill(4'h8, v);
        apply("all_m8", v, 32'h1000);
        v = '0;
        v[3:0] = 4'h7;
        apply("op0_7", v, 32'h0007);
        v[3:0] = 4'h8;
        apply("op0_m8", v, 32'h1FF8);
        for (int i = 0; i < 512; i++) v[i*4 +: 4] = (i % 2 == 0) ? 4'h7 : 4'h8;
        apply("alt_7_m8", v, 32'h1F00);

        // Asynchronous reset pulsed between edges with nonzero operands.
        fill(4'hF, v);
        apply("pre_rst", v, 32'h1E00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_sum", int'(sum_b), 0);
        check("arst_cout", int'(cout_b), 0);
        @(posedge clk);
        #1;
        check("hold_sum", int'(sum_b), 0);
        check("hold_cout", int'(cout_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst", big_total(), 32'h1E00);

        // LFSR stream against the accumulate model.
        a_big = '1;
        for (int k = 0; k < 2000; k++) begin
            v = a_big;
            @(posedge clk);
            #1;
            check("lfsr", big_total(), ref_sum(v, 512) & 32'h1FFF);
            a_big = {a_big[2046:0], a_big[2047] ^ a_big[2046]};
        end

        // Small configurations with random vectors.
        for (int k = 0; k < 200; k++) begin
            for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
            v = '0;
            v[255:0] = r;
            @(posedge clk);
            #1;
            check("n1",  (int'(s1)  + int'(c1))  & 32'h1F,  ref_sum(v, 1)  & 32'h1F);
            check("n2",  (int'(s2)  + int'(c2))  & 32'h1F,  ref_sum(v, 2)  & 32'h1F);
            check("n3",  (int'(s3)  + int'(c3))  & 32'h1F,  ref_sum(v, 3)  & 32'h1F);
            check("n9",  (int'(s9)  + int'(c9))  & 32'h7F,  ref_sum(v, 9)  & 32'h7F);
            check("n25", (int'(s25) + int'(c25)) & 32'hFF,  ref_sum(v, 25) & 32'hFF);
            check("n64", (int'(s64) + int'(c64)) & 32'h3FF, ref_sum(v, 64) & 32'h3FF);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
